// File: rtl/bus_master_ctl_pkg.sv
// Shared definitions for the per-master bus controller: active-low levels,
// FSM state encodings and read/write encodings.
package bus_master_ctl_pkg;

  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  typedef enum logic [1:0] {
    BM_IDLE = 2'b00,
    BM_REQ  = 2'b01,
    BM_BUS  = 2'b10,
    BM_DONE = 2'b11
  } bm_state_e;

endpackage

// File: rtl/bus_master_ctl.sv
// Per-master bus interface controller: turns a core request pulse into an
// arbitration handshake, runs one bus transfer and reports completion.
module bus_master_ctl
  import bus_master_ctl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              breq_,
  input  logic              bgrt_,
  output logic              bus_as_,
  output logic              bus_oe,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rdy_
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  bm_state_e       state_q;
  logic [CntW-1:0] cnt_q;

  logic rdy_hit, tmo_hit, lost_hit;
  assign rdy_hit  = (bus_rdy_ == Enable_);
  assign tmo_hit  = (cnt_q == CntLast);
  assign lost_hit = (bgrt_ == Disable_);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BM_IDLE;
      breq_     <= Disable_;
      bus_as_   <= Disable_;
      bus_oe    <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      bus_rw    <= BUS_READ;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cnt_q     <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      unique case (state_q)
        BM_IDLE: begin
          if (core_req) begin
            bus_rw    <= core_rw;
            bus_addr  <= core_addr;
            bus_wdata <= core_wdata;
            breq_     <= Enable_;
            busy      <= 1'b1;
            state_q   <= BM_REQ;
          end
        end
        BM_REQ: begin
          if (bgrt_ == Enable_) begin
            bus_as_ <= Enable_;
            bus_oe  <= 1'b1;
            cnt_q   <= '0;
            state_q <= BM_BUS;
          end
        end
        BM_BUS: begin
          if (cnt_q != CntMax) cnt_q <= cnt_q + CntW'(1);
          if (rdy_hit || tmo_hit || lost_hit) begin
            bus_as_ <= Disable_;
            bus_oe  <= 1'b0;
            breq_   <= Disable_;
            ack     <= 1'b1;
            state_q <= BM_DONE;
            // Slave ready wins over timeout and lost grant.
            if (rdy_hit) begin
              if (bus_rw == BUS_READ) rdata <= bus_rdata;
            end else begin
              err <= 1'b1;
            end
          end
        end
        BM_DONE: begin
          busy    <= 1'b0;
          state_q <= BM_IDLE;
        end
        default: state_q <= BM_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_master_ctl.md
Name: bus_master_ctl

Overview:
- Per-master bus interface controller, sitting directly upstream of the two-master bus arbiter. One instance per master; master 0's `breq_` feeds arbiter `breq0_`, master 1's feeds `breq1_`.
- Converts a single-cycle core access request into the arbitration handshake (`breq_`/`bgrt_`), then runs one shared-bus read or write and reports completion.
- Guards against hung slaves with a timeout and returns the read data to the core.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles in BUS state waiting for `bus_rdy_` (≥1).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  access request pulse; accepted only when busy=0.
- core_rw  in  1  1=read, 0=write; sampled with core_req.
- core_addr  in  ADDR_W  access address; sampled with core_req.
- core_wdata  in  DATA_W  write data; sampled with core_req.
- busy  out  1  high from the cycle after acceptance until completion.
- ack  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with ack on timeout or lost grant.
- rdata  out  DATA_W  read data; holds until the next successful read.
- breq_  out  1  bus request to arbiter, active-low.
- bgrt_  in  1  bus grant from arbiter, active-low.
- bus_as_  out  1  address strobe, active-low.
- bus_oe  out  1  drive enable for external bus mux/tristate.
- bus_rw  out  1  registered copy of core_rw.
- bus_addr  out  ADDR_W  registered address.
- bus_wdata  out  DATA_W  registered write data.
- bus_rdata  in  DATA_W  slave read data.
- bus_rdy_  in  1  slave ready, active-low.

Behaviour:
- Active-low signals use the shared Enable_ (0) / Disable_ (1) constants.
- Reset, sampled at posedge:
  - state=IDLE, breq_=Disable_, bus_as_=Disable_.
  - bus_oe=0, busy=0, ack=0, err=0.
  - rdata=0, bus_rw=1, bus_addr=0, bus_wdata=0, timeout counter=0.
  - Reset during any state aborts the access with no ack/err.
- All outputs are registered.
- States: IDLE, REQ, BUS, DONE.
- IDLE:
  - If core_req=1: latch rw/addr/wdata into bus_rw/bus_addr/bus_wdata; breq_<=Enable_; busy<=1; go to REQ.
- REQ:
  - Hold breq_ low and wait any number of cycles for bgrt_==Enable_.
  - On grant: bus_as_<=Enable_, bus_oe<=1, clear counter, go to BUS.
  - Earliest first strobe is 2 cycles after core_req.
- BUS:
  - bus_as_ and bus_oe held asserted; counter increments each cycle.
  - If bus_rdy_==Enable_: on a read, capture bus_rdata into rdata; go to DONE with ack<=1.
  - Else if counter==TIMEOUT-1: go to DONE with ack<=1, err<=1; rdata unchanged.
  - Else if bgrt_==Disable_ (grant lost, protocol violation): go to DONE with ack<=1, err<=1.
  - Priority when conditions coincide: rdy > timeout > grant lost.
  - On any exit: bus_as_<=Disable_, bus_oe<=0, breq_<=Disable_.
- DONE:
  - ack/err drop to 0; busy<=0; go to IDLE.
  - breq_ stays high here.
- breq_ is released for at least 2 cycles (DONE, then IDLE) between accesses, so the arbiter always sees a release and can hand the bus to the other master.
- core_req while busy=1 is ignored (not queued).
- Minimum access latency, core_req to ack (grant immediate, rdy in first BUS cycle): 3 cycles.
- Counter width: clog2(TIMEOUT+1) bits; it saturates, never wraps.

Decomposition:
- Shared defines file holds:
  - Enable_/Disable_.
  - State encodings BM_IDLE/BM_REQ/BM_BUS/BM_DONE (2-bit).
  - Read/write encodings BUS_READ=1, BUS_WRITE=0.
- No sub-module required. The timeout counter stays inline.

Test Plan:
- Read, immediate grant: core_req, rw=1, addr=0x1234; bgrt_ low 1 cycle after breq_; bus_rdy_ low in first BUS cycle with bus_rdata=0xDEADBEEF → ack 3 cycles after req; rdata=0xDEADBEEF; err=0; breq_ high next cycle.
- Write, delayed grant and 4-cycle slave: rw=0, wdata=0xA5A5A5A5; grant after 5 cycles; rdy_ after 4 BUS cycles → bus_as_ low exactly 4 cycles; bus_wdata stable; single ack; rdata unchanged.
- Timeout with TIMEOUT=8: bus_rdy_ never asserted → bus_as_ low 8 cycles; ack=err=1 in the same cycle; bus released.
- Two instances plus arbiter: both request the same cycle → master 0 served first; master 1 granted after master 0's breq_ release; no overlap of bus_oe.
- core_req pulsed while busy → ignored; exactly one ack.
- Reset asserted in BUS state → next cycle all outputs at reset values; no ack; a new request afterwards completes normally.
